ef_spi_slave: RTL and testbench

EF_SPI_SLAVE -- requirements
Module: ef_spi_slave

---
 rtl/ef_spi_slave_pkg.sv | 14 +
 rtl/ef_util_fifo.sv | 55 +++++
 rtl/ef_spi_slave.sv | 213 +++++++++++++++++++++
 tb/tb_ef_spi_slave.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ef_spi_slave_pkg.sv
// Shared definitions for the SPI slave: controller state encoding, frame width and underrun fill byte.
package ef_spi_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam int unsigned FRAME_W = 8;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);

    localparam logic [FRAME_W-1:0] UNDERRUN_FILL = 8'h00;

endpackage

// File: rtl/ef_util_fifo.sv
// Synchronous FIFO with first-word fall-through read data and occupancy level.
// Level is AW bits wide, so a completely full FIFO reports level 0 with full=1.
module ef_util_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full,
    output logic [AW-1:0] level
);

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          wr_ok;
    logic          rd_ok;

    // Flush takes priority over any push or pop in the same cycle.
    assign wr_ok = wr && !full && !flush;
    assign rd_ok = rd && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign empty = (count == '0);
    assign full  = count[AW];
    assign level = count[AW-1:0];

endmodule

// File: rtl/ef_spi_slave.sv
// SPI slave bus engine: synchronized bus inputs, 8-bit MSB-first frames in all four modes,
// TX/RX FIFOs with status, sticky underrun/overrun flags.
module ef_spi_slave
    import ef_spi_slave_pkg::*;
#(
    parameter int FAW  = 4,
    parameter int SYNC = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           CPOL,
    input  logic           CPHA,
    input  logic           wr,
    input  logic [7:0]     datai,
    input  logic           rd,
    output logic [7:0]     datao,
    input  logic           rx_flush,
    input  logic           tx_flush,
    input  logic [FAW-1:0] rx_threshold,
    input  logic [FAW-1:0] tx_threshold,
    output logic           rx_empty,
    output logic           rx_full,
    output logic           rx_level_above,
    output logic           tx_empty,
    output logic           tx_full,
    output logic           tx_level_below,
    output logic [FAW-1:0] rx_level,
    output logic [FAW-1:0] tx_level,
    output logic           busy,
    output logic           done,
    output logic           rx_overrun,
    output logic           tx_underrun,
    input  logic           err_clr,
    input  logic           sclk,
    input  logic           mosi,
    input  logic           csb,
    output logic           miso,
    output logic           miso_oe
);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

    logic [SYNC-1:0]    sclk_sync;
    logic [SYNC-1:0]    mosi_sync;
    logic [SYNC-1:0]    csb_sync;
    logic               sclk_s;
    logic               mosi_s;
    logic               csb_s;
    logic               sclk_d;
    logic               csb_d;
    logic               csb_fall;

    spi_state_t         state;
    spi_state_t         state_nx;
    logic               cpol_r;
    logic               cpha_r;
    logic               run;
    logic               lead;
    logic               trail;
    logic               load;
    logic               shift;
    logic               sample;
    logic               byte_done;

    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] tx_sh;
    logic [FRAME_W-1:0] rx_sh;
    logic [FRAME_W-1:0] rx_byte;
    logic               rx_push;

    logic [7:0]         tx_rdata;
    logic               tx_avail;
    logic               tx_pop;

    // Synchronizer chains shift in at bit 0; the width cast keeps the newest SYNC samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            csb_sync  <= '1;
            sclk_d    <= 1'b0;
            csb_d     <= 1'b1;
        end else begin
            sclk_sync <= SYNC'({sclk_sync, sclk});
            mosi_sync <= SYNC'({mosi_sync, mosi});
            csb_sync  <= SYNC'({csb_sync, csb});
            sclk_d    <= sclk_s;
            csb_d     <= csb_s;
        end
    end

    assign sclk_s   = sclk_sync[SYNC-1];
    assign mosi_s   = mosi_sync[SYNC-1];
    assign csb_s    = csb_sync[SYNC-1];
    assign csb_fall = csb_d && !csb_s;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        shift     = 1'b0;
        sample    = 1'b0;
        byte_done = 1'b0;
        run       = (state == ACTIVE) && !csb_s && enable;
        lead      = (sclk_d == cpol_r) && (sclk_s != cpol_r);
        trail     = (sclk_d != cpol_r) && (sclk_s == cpol_r);
        case (state)
            IDLE: begin
                if (csb_fall && enable) begin
                    state_nx = ACTIVE;
                    load     = !CPHA;
                end
            end
            ACTIVE: begin
                if (!run) begin
                    state_nx = IDLE;
                end else begin
                    // bit_cnt==0 on a drive edge means a byte boundary: load instead of shifting.
                    if (cpha_r) begin
                        sample = trail;
                        load   = lead && (bit_cnt == '0);
                        shift  = lead && (bit_cnt != '0);
                    end else begin
                        sample = lead;
                        load   = trail && (bit_cnt == '0);
                        shift  = trail && (bit_cnt != '0);
                    end
                    byte_done = sample && (bit_cnt == LAST_BIT);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign tx_avail = !tx_empty && !tx_flush;
    assign tx_pop   = load && tx_avail;

    always_ff @(posedge clk) begin
        if (rst) begin
            cpol_r      <= 1'b0;
            cpha_r      <= 1'b0;
            bit_cnt     <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            rx_byte     <= '0;
            rx_push     <= 1'b0;
            done        <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                cpol_r <= CPOL;
                cpha_r <= CPHA;
            end
            if (!run)        bit_cnt <= '0;
            else if (sample) bit_cnt <= bit_cnt + 1'b1;
            if (sample) rx_sh <= {rx_sh[FRAME_W-2:0], mosi_s};
            if (load)       tx_sh <= tx_avail ? tx_rdata : UNDERRUN_FILL;
            else if (shift) tx_sh <= {tx_sh[FRAME_W-2:0], 1'b0};
            done    <= byte_done;
            rx_push <= byte_done;
            if (byte_done) rx_byte <= {rx_sh[FRAME_W-2:0], mosi_s};
            if (load && !tx_avail) tx_underrun <= 1'b1;
            else if (err_clr)      tx_underrun <= 1'b0;
            if (rx_push && rx_full) rx_overrun <= 1'b1;
            else if (err_clr)       rx_overrun <= 1'b0;
        end
    end

    ef_util_fifo #(
        .DW(FRAME_W),
        .AW(FAW)
    ) u_rx_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(rx_flush),
        .wr   (rx_push),
        .wdata(rx_byte),
        .rd   (rd),
        .rdata(datao),
        .empty(rx_empty),
        .full (rx_full),
        .level(rx_level)
    );

    ef_util_fifo #(
        .DW(FRAME_W),
        .AW(FAW)
    ) u_tx_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(tx_flush),
        .wr   (wr),
        .wdata(datai),
        .rd   (tx_pop),
        .rdata(tx_rdata),
        .empty(tx_empty),
        .full (tx_full),
        .level(tx_level)
    );

    assign busy           = (state == ACTIVE);
    assign miso_oe        = busy;
    assign miso           = busy && tx_sh[FRAME_W-1];
    assign tx_level_below = (tx_level < tx_threshold);
    assign rx_level_above = (rx_level > rx_threshold);

endmodule

// File: tb/tb_ef_spi_slave.sv
// Directed bench for ef_spi_slave: a behavioural SPI master drives each mode and the
// FIFO/flag outputs are compared against hand-computed values.
module tb_ef_spi_slave;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       CPOL = 1'b0;
    logic       CPHA = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] datai = '0;
    logic       rd = 1'b0;
    logic [7:0] datao;
    logic       rx_flush = 1'b0;
    logic       tx_flush = 1'b0;
    logic [3:0] rx_threshold = 4'd1;
    logic [3:0] tx_threshold = 4'd2;
    logic       rx_empty, rx_full, rx_level_above;
    logic       tx_empty, tx_full, tx_level_below;
    logic [3:0] rx_level, tx_level;
    logic       busy, done, rx_overrun, tx_underrun;
    logic       err_clr = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       csb = 1'b1;
    logic       miso, miso_oe;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    ef_spi_slave #(.FAW(4), .SYNC(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .CPOL(CPOL), .CPHA(CPHA),
        .wr(wr), .datai(datai), .rd(rd), .datao(datao),
        .rx_flush(rx_flush), .tx_flush(tx_flush),
        .rx_threshold(rx_threshold), .tx_threshold(tx_threshold),
        .rx_empty(rx_empty), .rx_full(rx_full), .rx_level_above(rx_level_above),
        .tx_empty(tx_empty), .tx_full(tx_full), .tx_level_below(tx_level_below),
        .rx_level(rx_level), .tx_level(tx_level),
        .busy(busy), .done(done), .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
        .err_clr(err_clr), .sclk(sclk), .mosi(mosi), .csb(csb),
        .miso(miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        datai = b; wr = 1'b1; tick(1); wr = 1'b0;
    endtask

    task automatic pop_rx();
        rd = 1'b1; tick(1); rd = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        CPOL = pol; CPHA = pha; sclk = pol; tick(6);
    endtask

    task automatic spi_begin();
        csb = 1'b0; tick(H);
    endtask

    task automatic spi_end();
        tick(H); csb = 1'b1; tick(2 * H);
    endtask

    // Master side of one byte; nbits < 8 produces a truncated frame.
    task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] m);
        logic [7:0] sh;
        sh = b; m = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!CPHA) begin
                mosi = sh[7]; tick(H); m = {m[6:0], miso}; sclk = ~CPOL; tick(H); sclk = CPOL;
            end else begin
                sclk = ~CPOL; mosi = sh[7]; tick(H); m = {m[6:0], miso}; sclk = CPOL; tick(H);
            end
            sh = {sh[6:0], 1'b0};
        end
    endtask

    task automatic test_reset();
        vectors++; if ({busy, miso_oe, miso, done} !== 4'b0000) begin miscompares++;
            $display("FAIL reset_ctrl got %b want 0000", {busy, miso_oe, miso, done}); end
        vectors++; if ({rx_overrun, tx_underrun} !== 2'b00) begin miscompares++;
            $display("FAIL reset_flags got %b want 00", {rx_overrun, tx_underrun}); end
        vectors++; if ({rx_empty, tx_empty, rx_full, tx_full} !== 4'b1100) begin miscompares++;
            $display("FAIL reset_fifo got %b want 1100", {rx_empty, tx_empty, rx_full, tx_full}); end
        vectors++; if ({rx_level, tx_level} !== 8'h00) begin miscompares++;
            $display("FAIL reset_levels got %h want 00", {rx_level, tx_level}); end
        vectors++; if ({tx_level_below, rx_level_above} !== 2'b10) begin miscompares++;
            $display("FAIL reset_thresh got %b want 10", {tx_level_below, rx_level_above}); end
    endtask

    task automatic test_mode0();
        logic [7:0] m;
        int d0;
        set_mode(1'b0, 1'b0);
        push_tx(8'hA5);
        d0 = done_cnt;
        spi_begin();
        vectors++; if ({busy, miso_oe} !== 2'b11) begin miscompares++;
            $display("FAIL m0_busy got %b want 11", {busy, miso_oe}); end
        spi_byte(8'h3C, 8, m);
        spi_end();
        vectors++; if (m !== 8'hA5) begin miscompares++;
            $display("FAIL m0_miso got %h want a5", m); end
        vectors++; if (datao !== 8'h3C) begin miscompares++;
            $display("FAIL m0_rx got %h want 3c", datao); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++;
            $display("FAIL m0_done got %0d want 1", done_cnt - d0); end
        vectors++; if ({tx_empty, rx_level, busy, miso_oe} !== 7'b1_0001_00) begin miscompares++;
            $display("FAIL m0_status got %b want 1000100", {tx_empty, rx_level, busy, miso_oe}); end
        pop_rx();
        vectors++; if (rx_empty !== 1'b1) begin miscompares++;
            $display("FAIL m0_rx_empty got %b want 1", rx_empty); end
        clear_err();
    endtask

    task automatic test_modes();
        logic [7:0] m1, m2;
        int d0;
        for (int mode = 1; mode <= 3; mode++) begin
            set_mode(mode[1], mode[0]);
            push_tx(8'hC6);
            push_tx(8'h5B);
            vectors++; if ({tx_level, tx_level_below} !== 5'b0010_0) begin miscompares++;
                $display("FAIL mode%0d_txlvl got %b want 00100", mode, {tx_level, tx_level_below}); end
            d0 = done_cnt;
            spi_begin();
            spi_byte(8'h81, 8, m1);
            spi_byte(8'h7E, 8, m2);
            spi_end();
            vectors++; if ({m1, m2} !== 16'hC65B) begin miscompares++;
                $display("FAIL mode%0d_miso got %h want c65b", mode, {m1, m2}); end
            vectors++; if (done_cnt - d0 !== 2) begin miscompares++;
                $display("FAIL mode%0d_done got %0d want 2", mode, done_cnt - d0); end
            vectors++; if ({rx_level, rx_level_above, tx_empty, tx_level_below} !== 7'b0010_111) begin
                miscompares++;
                $display("FAIL mode%0d_status got %b want 0010111", mode,
                         {rx_level, rx_level_above, tx_empty, tx_level_below}); end
            vectors++; if (datao !== 8'h81) begin miscompares++;
                $display("FAIL mode%0d_rx0 got %h want 81", mode, datao); end
            pop_rx();
            vectors++; if (datao !== 8'h7E) begin miscompares++;
                $display("FAIL mode%0d_rx1 got %h want 7e", mode, datao); end
            pop_rx();
            vectors++; if (rx_empty !== 1'b1) begin miscompares++;
                $display("FAIL mode%0d_rx_empty got %b want 1", mode, rx_empty); end
            clear_err();
        end
        set_mode(1'b0, 1'b0);
    endtask

    task automatic test_underrun();
        logic [7:0] m;
        vectors++; if (tx_underrun !== 1'b0) begin miscompares++;
            $display("FAIL ur_pre got %b want 0", tx_underrun); end
        spi_begin();
        spi_byte(8'h55, 8, m);
        spi_end();
        vectors++; if (m !== 8'h00) begin miscompares++;
            $display("FAIL ur_miso got %h want 00", m); end
        tick(20);
        vectors++; if (tx_underrun !== 1'b1) begin miscompares++;
            $display("FAIL ur_flag got %b want 1", tx_underrun); end
        clear_err();
        vectors++; if (tx_underrun !== 1'b0) begin miscompares++;
            $display("FAIL ur_clr got %b want 0", tx_underrun); end
        vectors++; if (datao !== 8'h55) begin miscompares++;
            $display("FAIL ur_rx got %h want 55", datao); end
        pop_rx();
    endtask

    task automatic test_overrun();
        logic [7:0] m;
        spi_begin();
        for (int i = 0; i < 16; i++) spi_byte(8'(i), 8, m);
        spi_end();
        vectors++; if ({rx_full, rx_level, rx_overrun} !== 6'b1_0000_0) begin miscompares++;
            $display("FAIL ov_full got %b want 100000", {rx_full, rx_level, rx_overrun}); end
        spi_begin();
        spi_byte(8'hFF, 8, m);
        spi_end();
        vectors++; if ({rx_full, rx_level, rx_overrun} !== 6'b1_0000_1) begin miscompares++;
            $display("FAIL ov_flag got %b want 100001", {rx_full, rx_level, rx_overrun}); end
        for (int i = 0; i < 16; i++) begin
            vectors++; if (datao !== 8'(i)) begin miscompares++;
                $display("FAIL ov_rx%0d got %h want %h", i, datao, 8'(i)); end
            pop_rx();
        end
        vectors++; if (rx_empty !== 1'b1) begin miscompares++;
            $display("FAIL ov_drain got %b want 1", rx_empty); end
        clear_err();
        vectors++; if ({rx_overrun, tx_underrun} !== 2'b00) begin miscompares++;
            $display("FAIL ov_clr got %b want 00", {rx_overrun, tx_underrun}); end
    endtask

    task automatic test_abort();
        logic [7:0] m;
        int d0;
        d0 = done_cnt;
        spi_begin();
        spi_byte(8'hAA, 5, m);
        spi_end();
        vectors++; if (done_cnt - d0 !== 0) begin miscompares++;
            $display("FAIL ab_done got %0d want 0", done_cnt - d0); end
        vectors++; if ({rx_level, rx_empty, busy} !== 6'b0000_1_0) begin miscompares++;
            $display("FAIL ab_rx got %b want 000010", {rx_level, rx_empty, busy}); end
        spi_begin();
        spi_byte(8'hC3, 8, m);
        spi_end();
        vectors++; if (datao !== 8'hC3) begin miscompares++;
            $display("FAIL ab_next got %h want c3", datao); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++;
            $display("FAIL ab_next_done got %0d want 1", done_cnt - d0); end
        pop_rx();
        clear_err();
    endtask

    task automatic test_reset_mid();
        logic [7:0] m;
        int d0;
        push_tx(8'h77);
        push_tx(8'h88);
        spi_begin();
        spi_byte(8'hF0, 3, m);
        rst = 1'b1; csb = 1'b1; sclk = CPOL;
        tick(2);
        rst = 1'b0;
        tick(1);
        test_reset();
        d0 = done_cnt;
        spi_begin();
        spi_byte(8'h12, 8, m);
        spi_end();
        vectors++; if (datao !== 8'h12) begin miscompares++;
            $display("FAIL rm_rx got %h want 12", datao); end
        vectors++; if ({rx_level, done_cnt - d0 == 1} !== 5'b0001_1) begin miscompares++;
            $display("FAIL rm_level_done got %b/%0d want 0001/1", rx_level, done_cnt - d0); end
        pop_rx();
    endtask

    initial begin
        tick(4);
        rst = 1'b0;
        tick(2);
        test_reset();
        test_mode0();
        test_modes();
        test_underrun();
        test_overrun();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
